exu_hazard_ctrl: RTL and testbench

- Issue and hazard controller in front of the EXU.
- Tracks in-flight register writers with a per-register scoreboard and stalls ID→EX issue on RAW hazards.
- Sequences branch/jump redirects: drives the redirect pulse and the EXU_inst_clr squash window.
- Drains the pipeline for fence.i (fetch_i) instructions.

---
 rtl/exu_ctrl_pkg.sv | 15 +
 rtl/exu_scoreboard.sv | 59 +++++
 rtl/exu_hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_exu_hazard_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exu_ctrl_pkg.sv
// Shared types for the EXU issue/hazard controller: FSM states, register index, counter width.
package exu_ctrl_pkg;

    localparam int unsigned CNT_W_DEF = 2;
    localparam int unsigned REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        DRAIN
    } state_e;

endpackage

// File: rtl/exu_scoreboard.sv
// Per-register pending-writer counters with RAW-busy, single-writer, saturation and empty queries.
module exu_scoreboard
    import exu_ctrl_pkg::*;
#(
    parameter int unsigned NREG  = 32,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 inc_en,
    input  logic [REG_IDX_W-1:0] inc_idx,
    input  logic                 dec_en,
    input  logic [REG_IDX_W-1:0] dec_idx,
    input  logic [REG_IDX_W-1:0] rs1_idx,
    input  logic [REG_IDX_W-1:0] rs2_idx,
    input  logic [REG_IDX_W-1:0] rd_idx,
    output logic                 rs1_busy,
    output logic                 rs1_single,
    output logic                 rs2_busy,
    output logic                 rs2_single,
    output logic                 rd_full,
    output logic                 empty
);

    logic [NREG-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic                       inc_hit, dec_hit;

    // Entry 0 is never touched, so x0 always reads as idle.
    always_comb begin
        cnt_d   = cnt_q;
        inc_hit = 1'b0;
        dec_hit = 1'b0;
        for (int unsigned i = 1; i < NREG; i++) begin
            inc_hit = inc_en && (inc_idx == REG_IDX_W'(i));
            dec_hit = dec_en && (dec_idx == REG_IDX_W'(i)) && (cnt_q[i] != '0);
            if (inc_hit && !dec_hit) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (dec_hit && !inc_hit) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign rs1_busy   = (cnt_q[rs1_idx] != '0);
    assign rs1_single = (cnt_q[rs1_idx] == CNT_W'(1));
    assign rs2_busy   = (cnt_q[rs2_idx] != '0);
    assign rs2_single = (cnt_q[rs2_idx] == CNT_W'(1));
    assign rd_full    = (cnt_q[rd_idx] == '1);
    assign empty      = (cnt_q == '0);

endmodule

// File: rtl/exu_hazard_ctrl.sv
// ID->EX issue/hazard controller: RAW stalls, branch redirect squash window, fence.i drain.
// Optional EX->ID bypass excusing single-writer ALU hazards is enabled by EXU_FWD_EN.
module exu_hazard_ctrl
    import exu_ctrl_pkg::*;
#(
    parameter int unsigned NREG      = 32,
    parameter int unsigned CNT_W     = CNT_W_DEF,
    parameter int unsigned FLUSH_CYC = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic [4:0]  id_rd,
    input  logic        id_R_wen,
    input  logic        id_fetch_i,
    input  logic        ex_ready,
    input  logic        ex_valid,
    input  logic [4:0]  ex_rd,
    input  logic        ex_R_wen,
    input  logic        ex_mem_ren,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        wb_R_wen,
    input  logic        br_redirect,
    input  logic [31:0] br_target,
    output logic        id_ready,
    output logic        EXU_inst_clr,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        fencei_done,
    output logic        fwd_rs1,
    output logic        fwd_rs2
);

    localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYC - 1);

    state_e      state_q, state_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic        redirect_q, redirect_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic rs1_busy, rs1_single, rs2_busy, rs2_single, rd_full, sb_empty;
    logic hazard1, hazard2, sat, fire, inc_en, dec_en;

    exu_scoreboard #(
        .NREG  (NREG),
        .CNT_W (CNT_W)
    ) u_scoreboard (
        .clock      (clock),
        .reset      (reset),
        .inc_en     (inc_en),
        .inc_idx    (id_rd),
        .dec_en     (dec_en),
        .dec_idx    (wb_rd),
        .rs1_idx    (id_rs1),
        .rs2_idx    (id_rs2),
        .rd_idx     (id_rd),
        .rs1_busy   (rs1_busy),
        .rs1_single (rs1_single),
        .rs2_busy   (rs2_busy),
        .rs2_single (rs2_single),
        .rd_full    (rd_full),
        .empty      (sb_empty)
    );

`ifdef EXU_FWD_EN
    // Only a sole pending ALU writer sitting in EX can be bypassed; loads still stall.
    assign fwd_rs1 = id_rs1_used && (id_rs1 != '0) && rs1_single && ex_valid && ex_R_wen
                     && !ex_mem_ren && (ex_rd == id_rs1);
    assign fwd_rs2 = id_rs2_used && (id_rs2 != '0) && rs2_single && ex_valid && ex_R_wen
                     && !ex_mem_ren && (ex_rd == id_rs2);
`else
    logic unused_fwd;
    assign unused_fwd = ^{ex_rd, ex_R_wen, ex_mem_ren, rs1_single, rs2_single};
    assign fwd_rs1    = 1'b0;
    assign fwd_rs2    = 1'b0;
`endif

    assign hazard1      = id_rs1_used && (id_rs1 != '0) && rs1_busy && !fwd_rs1;
    assign hazard2      = id_rs2_used && (id_rs2 != '0) && rs2_busy && !fwd_rs2;
    assign sat          = id_R_wen && (id_rd != '0) && rd_full;
    assign id_ready     = ex_ready && (state_q == RUN) && !br_redirect && !hazard1 && !hazard2 && !sat;
    assign fire         = id_valid && id_ready;
    assign EXU_inst_clr = br_redirect || (state_q == FLUSH);
    assign inc_en       = fire && id_R_wen && (id_rd != '0) && !EXU_inst_clr;
    assign dec_en       = wb_valid && wb_R_wen && (wb_rd != '0);

    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        fencei_done   = 1'b0;
        redirect_d    = br_redirect;
        redirect_pc_d = br_redirect ? br_target : redirect_pc_q;
        // A redirect overrides every state, including a pending drain or flush.
        if (br_redirect) begin
            state_d     = FLUSH;
            flush_cnt_d = FLUSH_LAST;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (fire && id_fetch_i) state_d = DRAIN;
                end
                FLUSH: begin
                    if (flush_cnt_q == '0) state_d = RUN;
                    else                   flush_cnt_d = flush_cnt_q - 3'd1;
                end
                DRAIN: begin
                    if (sb_empty && !ex_valid) begin
                        state_d     = RUN;
                        fencei_done = 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= RUN;
            flush_cnt_q   <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_exu_hazard_ctrl.sv
// Table-driven bench for exu_hazard_ctrl with a redirect-target scoreboard queue.
module tb_exu_hazard_ctrl;

`ifdef EXU_FWD_EN
    localparam logic FWD = 1'b1;
`else
    localparam logic FWD = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        id_valid, id_rs1_used, id_rs2_used, id_R_wen, id_fetch_i;
    logic [4:0]  id_rs1, id_rs2, id_rd, ex_rd, wb_rd;
    logic        ex_ready, ex_valid, ex_R_wen, ex_mem_ren, wb_valid, wb_R_wen, br_redirect;
    logic [31:0] br_target;
    logic        id_ready, EXU_inst_clr, redirect, fencei_done, fwd_rs1, fwd_rs2;
    logic [31:0] redirect_pc;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_pc_q[$];

    typedef struct {
        logic       valid;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       wen;
        logic       fi;
        logic       exrdy;
        logic       exv;
        logic       exwen;
        logic [4:0] exrd;
        logic       exmren;
        logic [4:0] wbrd;
        logic       br;
        logic [31:0] tgt;
        logic       e_rdy;
        logic       e_clr;
        logic       e_done;
        logic       e_f1;
        logic       e_f2;
    } vec_t;

    vec_t tbl[$];

    exu_hazard_ctrl #(
        .NREG      (32),
        .CNT_W     (2),
        .FLUSH_CYC (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .id_rd        (id_rd),
        .id_R_wen     (id_R_wen),
        .id_fetch_i   (id_fetch_i),
        .ex_ready     (ex_ready),
        .ex_valid     (ex_valid),
        .ex_rd        (ex_rd),
        .ex_R_wen     (ex_R_wen),
        .ex_mem_ren   (ex_mem_ren),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_R_wen     (wb_R_wen),
        .br_redirect  (br_redirect),
        .br_target    (br_target),
        .id_ready     (id_ready),
        .EXU_inst_clr (EXU_inst_clr),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .fencei_done  (fencei_done),
        .fwd_rs1      (fwd_rs1),
        .fwd_rs2      (fwd_rs2)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic valid, input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                                input logic wen, input logic fi, input logic exv,
                                input logic [4:0] wbrd, input logic br, input logic [31:0] tgt,
                                input logic rdy, input logic clr, input logic done);
        vec_t t;
        t.valid = valid; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2;
        t.rd = rd; t.wen = wen; t.fi = fi; t.exrdy = 1'b1; t.exv = exv;
        t.exwen = 1'b0; t.exrd = 5'd0; t.exmren = 1'b0; t.wbrd = wbrd;
        t.br = br; t.tgt = tgt;
        t.e_rdy = rdy; t.e_clr = clr; t.e_done = done; t.e_f1 = 1'b0; t.e_f2 = 1'b0;
        return t;
    endfunction

    task automatic drive(input vec_t t);
        id_valid = t.valid; id_rs1 = t.rs1; id_rs1_used = t.u1; id_rs2 = t.rs2;
        id_rs2_used = t.u2; id_rd = t.rd; id_R_wen = t.wen; id_fetch_i = t.fi;
        ex_ready = t.exrdy; ex_valid = t.exv; ex_R_wen = t.exwen; ex_rd = t.exrd;
        ex_mem_ren = t.exmren; wb_valid = (t.wbrd != 5'd0); wb_R_wen = (t.wbrd != 5'd0);
        wb_rd = t.wbrd; br_redirect = t.br; br_target = t.tgt;
    endtask

    // Scoreboard side: every redirect pulse must consume the oldest expected target.
    always @(negedge clock) begin
        if (reset && redirect) begin
            if (exp_pc_q.size() == 0) begin
                chk("redirect_unexpected", 32'(redirect), 32'd0);
            end else begin
                chk("redirect_pc", redirect_pc, exp_pc_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t t;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        ex_ready = 1'b0;

        // Stalled RAW on x5 until its write-back, then x5 is idle again.
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 5, 1, 0, 0, 6, 1, 0, 0, 5, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 5, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        // x0 writers and readers never stall.
        for (int k = 0; k < 4; k++) tbl.push_back(mk(1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        // x7: same-cycle inc/dec holds, saturation at 3 stalls the fourth writer.
        tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 7, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 7, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        // Redirect: three-cycle squash window, squashed x8 writers are not counted.
        tbl.push_back(mk(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 1, 32'h8000_0040, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        // fence.i with two writers in flight.
        tbl.push_back(mk(1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 11, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 12, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 12, 1, 0, 1, 10, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 12, 1, 0, 0, 11, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 12, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 12, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 12, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 12, 0, 0, 1, 0, 0));
        // Redirect during DRAIN suppresses fencei_done; a second redirect restarts the flush.
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1234_5678, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFE_0000, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        t = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        t.exrdy = 1'b0;
        tbl.push_back(t);
        // Bypass from an ALU writer of x9 in EX; loads in EX always stall.
        tbl.push_back(mk(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        t = mk(1, 9, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, FWD, 0, 0);
        t.exwen = 1'b1; t.exrd = 5'd9; t.e_f1 = FWD;
        tbl.push_back(t);
        t.exmren = 1'b1; t.e_rdy = 1'b0; t.e_f1 = 1'b0;
        tbl.push_back(t);
        t = mk(1, 0, 0, 9, 1, 0, 0, 0, 1, 0, 0, 0, FWD, 0, 0);
        t.exwen = 1'b1; t.exrd = 5'd9; t.e_f2 = FWD;
        tbl.push_back(t);
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 1, 0, 0));

        repeat (2) @(negedge clock);
        chk("rst.id_ready", 32'(id_ready), 32'd0);
        chk("rst.clr", 32'(EXU_inst_clr), 32'd0);
        chk("rst.redirect", 32'(redirect), 32'd0);
        chk("rst.redirect_pc", redirect_pc, 32'd0);
        chk("rst.fencei_done", 32'(fencei_done), 32'd0);
        chk("rst.fwd", {30'd0, fwd_rs1, fwd_rs2}, 32'd0);
        reset = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clock);
            drive(tbl[i]);
            if (tbl[i].br) exp_pc_q.push_back(tbl[i].tgt);
            #1;
            chk($sformatf("v%0d.id_ready", i), 32'(id_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("v%0d.clr", i), 32'(EXU_inst_clr), 32'(tbl[i].e_clr));
            chk($sformatf("v%0d.fencei_done", i), 32'(fencei_done), 32'(tbl[i].e_done));
            chk($sformatf("v%0d.fwd_rs1", i), 32'(fwd_rs1), 32'(tbl[i].e_f1));
            chk($sformatf("v%0d.fwd_rs2", i), 32'(fwd_rs2), 32'(tbl[i].e_f2));
        end

        // Asynchronous reset mid-flush with a pending x13 writer.
        @(negedge clock);
        drive(mk(1, 0, 0, 0, 0, 13, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("mid.issue_x13", 32'(id_ready), 32'd1);
        @(negedge clock);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEC, 0, 0, 0));
        @(posedge clock);
        #2;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        ex_ready = 1'b0;
        reset = 1'b0;
        #1;
        chk("mid.clr", 32'(EXU_inst_clr), 32'd0);
        chk("mid.redirect", 32'(redirect), 32'd0);
        chk("mid.redirect_pc", redirect_pc, 32'd0);
        chk("mid.id_ready", 32'(id_ready), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        drive(mk(1, 13, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("post.id_ready", 32'(id_ready), 32'd1);
        chk("post.clr", 32'(EXU_inst_clr), 32'd0);
        @(negedge clock);
        chk("redirect_q_empty", 32'(exp_pc_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
